// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: issue, writeback, query, rename-in, commit and flush signals of the reorder buffer
//   master : pipeline side, drives issue_*, wb_*, qry*_tag
//   slave  : reorder buffer, drives issue_ready/tag, qry*_ready/val, rd_in_*, rd_out_*, flush*
interface reorder_buffer_if #(parameter int TAG_W = 4);
   logic             issue_valid;
   logic             issue_has_rd;
   logic [4:0]       issue_rd;
   logic             issue_ready;
   logic [TAG_W-1:0] issue_tag;
   logic             wb_valid;
   logic [TAG_W-1:0] wb_tag;
   logic [31:0]      wb_val;
   logic             wb_mispredict;
   logic [31:0]      wb_target;
   logic [TAG_W-1:0] qry1_tag;
   logic             qry1_ready;
   logic [31:0]      qry1_val;
   logic [TAG_W-1:0] qry2_tag;
   logic             qry2_ready;
   logic [31:0]      qry2_val;
   logic             rd_in_flag;
   logic [4:0]       rd_in_a;
   logic [TAG_W-1:0] rd_in_rob;
   logic             rd_out_flag;
   logic [4:0]       rd_out_a;
   logic [31:0]      rd_out_val;
   logic [TAG_W-1:0] rd_out_rob;
   logic             flush;
   logic [31:0]      flush_pc;
   modport master (
      output issue_valid, issue_has_rd, issue_rd, wb_valid, wb_tag, wb_val, wb_mispredict, wb_target,
             qry1_tag, qry2_tag,
      input  issue_ready, issue_tag, qry1_ready, qry1_val, qry2_ready, qry2_val,
             rd_in_flag, rd_in_a, rd_in_rob, rd_out_flag, rd_out_a, rd_out_val, rd_out_rob, flush, flush_pc
   );
   modport slave (
      input  issue_valid, issue_has_rd, issue_rd, wb_valid, wb_tag, wb_val, wb_mispredict, wb_target,
             qry1_tag, qry2_tag,
      output issue_ready, issue_tag, qry1_ready, qry1_val, qry2_ready, qry2_val,
             rd_in_flag, rd_in_a, rd_in_rob, rd_out_flag, rd_out_a, rd_out_val, rd_out_rob, flush, flush_pc
   );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue with CDB capture, operand query and mispredict flush
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   rdy        : global enable, 0 holds all state
//   rob        : reorder_buffer_if slave (issue, writeback, queries, rename-in, commit, flush)
module reorder_buffer #(
   parameter int DEPTH = 16,
   parameter int TAG_W = 4
) (
   input logic              clk,
   input logic              rst_n,
   input logic              rdy,
   reorder_buffer_if.slave  rob
);
   logic [TAG_W-1:0] head, tail;
   logic [TAG_W:0]   count;
   logic [DEPTH-1:0] busy, done, has_rd, misp;
   logic [4:0]       rd     [DEPTH];
   logic [31:0]      val    [DEPTH];
   logic [31:0]      target [DEPTH];
   logic             head_ok, flush_now, accept, commit, wb_hit;
   logic             q1_byp, q1_have, q2_byp, q2_have;
   // head done with a mispredict: blocks allocation so the flush sees an empty tail
   assign head_ok   = busy[head] & done[head];
   assign flush_now = head_ok & misp[head];
   assign rob.issue_ready = (count != (TAG_W+1)'(DEPTH)) & ~flush_now;
   assign rob.issue_tag   = tail;
   assign accept = rdy & rob.issue_valid & rob.issue_ready;
   assign commit = rdy & head_ok;
   assign wb_hit = rdy & rob.wb_valid & busy[rob.wb_tag];
   assign rob.rd_in_flag = accept & rob.issue_has_rd & (rob.issue_rd != 5'd0);
   assign rob.rd_in_a    = rob.issue_rd;
   assign rob.rd_in_rob  = tail;
   // a live CDB result for a busy tag is forwarded ahead of the stored value
   assign q1_byp  = rob.wb_valid & (rob.wb_tag == rob.qry1_tag) & busy[rob.qry1_tag];
   assign q1_have = busy[rob.qry1_tag] & done[rob.qry1_tag];
   assign q2_byp  = rob.wb_valid & (rob.wb_tag == rob.qry2_tag) & busy[rob.qry2_tag];
   assign q2_have = busy[rob.qry2_tag] & done[rob.qry2_tag];
   assign rob.qry1_ready = q1_byp | q1_have;
   assign rob.qry1_val   = q1_byp ? rob.wb_val : q1_have ? val[rob.qry1_tag] : 32'd0;
   assign rob.qry2_ready = q2_byp | q2_have;
   assign rob.qry2_val   = q2_byp ? rob.wb_val : q2_have ? val[rob.qry2_tag] : 32'd0;
   // payload needs no reset: it is only read behind busy/done
   always_ff @(posedge clk) begin
      if (accept) begin
         has_rd[tail] <= rob.issue_has_rd;
         rd[tail]     <= rob.issue_rd;
      end
      if (wb_hit) begin
         val[rob.wb_tag]    <= rob.wb_val;
         misp[rob.wb_tag]   <= rob.wb_mispredict;
         target[rob.wb_tag] <= rob.wb_target;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         busy            <= '0;
         done            <= '0;
         rob.rd_out_flag <= 1'b0;
         rob.rd_out_a    <= '0;
         rob.rd_out_val  <= '0;
         rob.rd_out_rob  <= '0;
         rob.flush       <= 1'b0;
         rob.flush_pc    <= '0;
      end else begin
         if (accept) begin
            busy[tail] <= 1'b1;
            done[tail] <= 1'b0;
            tail       <= tail + 1'b1;
         end
         if (wb_hit) done[rob.wb_tag] <= 1'b1;
         if (commit) begin
            busy[head]     <= 1'b0;
            head           <= head + 1'b1;
            rob.rd_out_a   <= rd[head];
            rob.rd_out_val <= val[head];
            rob.rd_out_rob <= head;
         end
         rob.rd_out_flag <= commit & has_rd[head] & (rd[head] != 5'd0);
         rob.flush       <= commit & misp[head];
         count           <= (commit & flush_now) ? '0 : count + (TAG_W+1)'(accept) - (TAG_W+1)'(commit);
         // mispredict retire discards everything younger than the head
         if (commit & flush_now) begin
            rob.flush_pc <= target[head];
            busy         <= '0;
            done         <= '0;
            head         <= '0;
            tail         <= '0;
         end
      end
   end
endmodule
